// File: rtl/beat_ctrl.sv
// Purpose : multi-cycle CPU sequencer; emits one-hot beats t0..t3 and arbitrates the shared memory bus (fetch / execute).
// Latency : all outputs registered; minimum instruction is 5 cycles (IF,T0,T1,T2,T3), IF and T2 stretch on bus_ready.
// Backpr. : bus_ready low holds the current bus command; WAIT_LIMIT consecutive waits trap into ERR until reset.
// Ports   : run/halt_req control, pc + ex_* requests in; t0..t3 beats, bus_rd/bus_wr/bus_addr/bus_owner,
//           running, sticky bus_err and retired-instruction count out. rst is asynchronous active-low.
module beat_ctrl #(
    parameter int AW         = 16,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic [AW-1:0]    pc,
    input  logic             ex_mem_req,
    input  logic             ex_mem_we,
    input  logic [AW-1:0]    ex_addr,
    input  logic             bus_ready,
    output logic             t0,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             bus_rd,
    output logic             bus_wr,
    output logic [AW-1:0]    bus_addr,
    output logic             bus_owner,
    output logic             running,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_T0   = 3'd2,
        S_T1   = 3'd3,
        S_T2   = 3'd4,
        S_T3   = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // WAIT_LIMIT is bounded to 255, so an 8-bit wait counter always suffices.
    localparam int             WCW      = 8;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

    state_t            state_q, state_d;
    logic [WCW-1:0]    wait_q, wait_d, wait_inc;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              cmd_ex;

    logic              t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic              bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
    logic [AW-1:0]     bus_addr_q, bus_addr_d;
    logic              bus_owner_q, bus_owner_d;
    logic              running_q, running_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wait_inc = wait_q + WCW'(1);

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_IF;
            end
            S_IF: begin
                if (bus_ready) begin
                    state_d = S_T0;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_MAX) state_d = S_ERR;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                req_d   = ex_mem_req;
                we_d    = ex_mem_we;
                addr_d  = ex_addr;
                state_d = S_T2;
            end
            S_T2: begin
                if (!req_q) begin
                    state_d = S_T3;
                end else if (bus_ready) begin
                    state_d = S_T3;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_MAX) state_d = S_ERR;
                end
            end
            S_T3:    state_d = halt_req ? S_IDLE : S_IF;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state they describe.
        // The T2 command uses req_d/addr_d so a request latched at the T1->T2 edge is on the bus in the first T2 cycle.
        cmd_ex      = (state_d == S_T2) && req_d;
        t0_d        = (state_d == S_T0);
        t1_d        = (state_d == S_T1);
        t2_d        = (state_d == S_T2);
        t3_d        = (state_d == S_T3);
        bus_rd_d    = (state_d == S_IF) || (cmd_ex && !we_d);
        bus_wr_d    = cmd_ex && we_d;
        bus_owner_d = cmd_ex;
        bus_addr_d  = (state_d == S_IF) ? pc : (cmd_ex ? addr_d : '0);
        running_d   = (state_d != S_IDLE) && (state_d != S_ERR);
        bus_err_d   = (state_d == S_ERR);
        retired_d   = (state_q == S_T3) ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            t0_q        <= 1'b0;
            t1_q        <= 1'b0;
            t2_q        <= 1'b0;
            t3_q        <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_owner_q <= 1'b0;
            running_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t3_q        <= t3_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_owner_q <= bus_owner_d;
            running_q   <= running_d;
            bus_err_q   <= bus_err_d;
            retired_q   <= retired_d;
        end
    end

    assign t0        = t0_q;
    assign t1        = t1_q;
    assign t2        = t2_q;
    assign t3        = t3_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_owner = bus_owner_q;
    assign running   = running_q;
    assign bus_err   = bus_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_beat_ctrl.sv
// Purpose : self-checking bench for beat_ctrl; expected per-cycle traces are built from instruction-level phases.
// Latency : each queued record covers one clock; outputs are sampled 1 time unit after the rising edge.
// Backpr. : bench owns bus_ready, so every wait state and timeout is scheduled by the bench itself.
module tb_beat_ctrl;

    localparam int AW = 16;
    localparam int WL = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0, halt_req = 1'b0, ex_mem_req = 1'b0, ex_mem_we = 1'b0, bus_ready = 1'b0;
    logic [AW-1:0] pc = '0, ex_addr = '0;
    logic          t0, t1, t2, t3, bus_rd, bus_wr, bus_owner, running, bus_err;
    logic [AW-1:0] bus_addr;
    logic [CW-1:0] retired;

    beat_ctrl #(.AW(AW), .WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .pc(pc),
        .ex_mem_req(ex_mem_req), .ex_mem_we(ex_mem_we), .ex_addr(ex_addr), .bus_ready(bus_ready),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_owner(bus_owner), .running(running), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // One clock of expected outputs plus the inputs the bench drives during that clock.
    typedef struct {
        logic [3:0]  t;      // {t3,t2,t1,t0}
        logic        rd, wr, own, runn, err;
        logic [15:0] addr;
        logic        d_run, d_halt, d_req, d_we, d_rdy;
        logic [15:0] d_ea, d_pc;
    } cyc_t;

    cyc_t          q[$];
    logic [40:0]   got_v[$];
    logic [40:0]   exp_v[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic [CW-1:0] exp_ret = '0;
    bit            m_idle = 1'b1;
    logic [15:0]   m_pc = '0;
    bit            rdy_one = 1'b0;

    // Idle-looking record; inputs the DUT must ignore are randomised.
    function automatic cyc_t blank();
        cyc_t c;
        c.t = 4'b0000; c.rd = 0; c.wr = 0; c.own = 0; c.runn = 0; c.err = 0; c.addr = '0;
        c.d_run = 0; c.d_halt = 1'($urandom); c.d_req = 1'($urandom); c.d_we = 1'($urandom);
        c.d_rdy = rdy_one ? 1'b1 : 1'($urandom);
        c.d_ea = 16'($urandom); c.d_pc = m_pc;
        return c;
    endfunction

    task automatic push_idle(input bit go);
        cyc_t c = blank();
        c.d_run = go;
        q.push_back(c);
    endtask

    task automatic push_act(input cyc_t c);
        c.runn  = 1'b1;
        c.d_run = 1'($urandom);   // run while active must be ignored
        q.push_back(c);
    endtask

    // One instruction: fetch (fw wait cycles), T0, T1, T2 (optional access, ew waits), T3.
    task automatic add_instr(input int fw, input bit mem, input bit we, input logic [15:0] ea,
                             input int ew, input bit halt);
        cyc_t c;
        if (m_idle) begin push_idle(1'b1); m_idle = 1'b0; end
        for (int i = 0; i <= fw; i++) begin
            c = blank(); c.rd = 1; c.addr = m_pc; c.d_rdy = (i == fw); push_act(c);
        end
        c = blank(); c.t = 4'b0001; push_act(c);
        m_pc = m_pc + 16'd2;
        c = blank(); c.t = 4'b0010; c.d_req = mem; c.d_we = we; c.d_ea = ea; push_act(c);
        if (!mem) begin
            c = blank(); c.t = 4'b0100; push_act(c);
        end else begin
            for (int i = 0; i <= ew; i++) begin
                c = blank(); c.t = 4'b0100; c.rd = !we; c.wr = we; c.own = 1; c.addr = ea;
                c.d_rdy = (i == ew); push_act(c);
            end
        end
        c = blank(); c.t = 4'b1000; c.d_halt = halt; push_act(c);
        if (halt) m_idle = 1'b1;
    endtask

    task automatic run_queue(input int n);
        cyc_t c;
        got_v.delete(); exp_v.delete();
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            @(posedge clk); #1;
            got_v.push_back({retired, t3, t2, t1, t0, bus_rd, bus_wr, bus_owner, bus_addr, running, bus_err});
            exp_v.push_back({exp_ret, c.t, c.rd, c.wr, c.own, c.addr, c.runn, c.err});
            if (c.t[3]) exp_ret = exp_ret + 1'b1;
            run = c.d_run; halt_req = c.d_halt; ex_mem_req = c.d_req; ex_mem_we = c.d_we;
            ex_addr = c.d_ea; pc = c.d_pc; bus_ready = c.d_rdy;
        end
        q.delete();
    endtask

    task automatic quiet_inputs();
        run = 0; halt_req = 0; ex_mem_req = 0; ex_mem_we = 0; bus_ready = 0;
    endtask

    task automatic test_reset();
        logic [40:0] g;
        quiet_inputs();
        #2 rst = 1'b0;
        #1;
        g = {retired, t3, t2, t1, t0, bus_rd, bus_wr, bus_owner, bus_addr, running, bus_err};
        n_total++;
        if (g !== 41'd0) $display("FAIL reset_state got=%h exp=%h", g, 41'd0); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ret = '0; m_idle = 1'b1;
    endtask

    task automatic test_min_loop();
        rdy_one = 1'b1; m_pc = 16'h0000;
        for (int i = 0; i < 4; i++) add_instr(0, 0, 0, 16'h0, 0, 0);
        run_queue(q.size());
        rdy_one = 1'b0;
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL min_loop cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fetch_wait();
        add_instr(3, 0, 0, 16'h0, 0, 0);
        add_instr(14, 1, 1, 16'h7FFE, 14, 0);   // max waits on both accesses, counter must restart
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL fetch_wait cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_store_wait();
        add_instr(0, 1, 1, 16'h0040, 2, 0);
        add_instr(1, 1, 0, 16'h0102, 1, 0);
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL store_wait cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_halt_restart();
        add_instr(1, 0, 0, 16'h0, 0, 1);
        m_pc = 16'h1230;
        repeat (3) push_idle(1'b0);
        add_instr(0, 1, 0, 16'h0ABC, 0, 0);
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL halt_restart cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int fw, ew;
        for (int n = 0; n < 25; n++) begin
            if (m_idle) begin
                m_pc = 16'($urandom) & 16'hFFFE;
                repeat ($urandom_range(0, 2)) push_idle(1'b0);
            end
            fw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, WL - 1) : $urandom_range(0, 2);
            ew = ($urandom_range(0, 4) == 0) ? $urandom_range(0, WL - 1) : $urandom_range(0, 2);
            add_instr(fw, 1'($urandom), 1'($urandom), 16'($urandom), ew, $urandom_range(0, 5) == 0);
        end
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL random cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [40:0] g;
        int n;
        add_instr(0, 1, 1, 16'h0010, 0, 0);                 // make sure retired is nonzero
        n = q.size();
        add_instr(0, 1, 0, 16'h0200, 10, 0);                // load that will be cut off
        run_queue(n + 6);                                   // IF, T0, T1 and 3 waiting T2 cycles
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL pre_reset cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
        quiet_inputs();
        #2 rst = 1'b0;
        #1;
        g = {retired, t3, t2, t1, t0, bus_rd, bus_wr, bus_owner, bus_addr, running, bus_err};
        n_total++;
        if (g !== 41'd0) $display("FAIL reset_mid_t2 got=%h exp=%h", g, 41'd0); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_ret = '0; m_idle = 1'b1;
        add_instr(0, 0, 0, 16'h0, 0, 0);
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL post_reset cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        logic [1:0] g;
        if (m_idle) begin push_idle(1'b1); m_idle = 1'b0; end
        for (int i = 0; i < WL; i++) begin
            c = blank(); c.rd = 1; c.addr = m_pc; c.d_rdy = 1'b0; push_act(c);
        end
        for (int i = 0; i < 6; i++) begin
            c = blank(); c.err = 1; c.d_run = 1'($urandom); q.push_back(c);
        end
        run_queue(q.size());
        for (int i = 0; i < exp_v.size(); i++) begin
            n_total++;
            if (got_v[i] !== exp_v[i]) $display("FAIL timeout cyc%0d got=%h exp=%h", i, got_v[i], exp_v[i]);
            else n_pass++;
        end
        quiet_inputs();
        #2 rst = 1'b0;
        #1;
        g = {bus_err, running};
        n_total++;
        if (g !== 2'b00) $display("FAIL err_cleared got=%b exp=%b", g, 2'b00); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_ret = '0; m_idle = 1'b1;
    endtask

    initial begin
        test_reset();
        test_min_loop();
        test_fetch_wait();
        test_store_wait();
        test_halt_restart();
        test_random();
        test_reset_mid_access();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/beat_ctrl.md
Name: beat_ctrl

Overview:
- Central sequencer for the multi-cycle CPU.
- Generates the one-hot beat strobes t0..t3 that clock the fetch and execute stages.
- Owns the single shared memory bus and grants it either to instruction fetch (address = pc) or to execute-stage load/store.
- Inserts wait states on bus_ready, detects hung bus accesses, and handles run/halt control.

Parameters:
AW, 16, address width of pc, ex_addr and bus_addr
WAIT_LIMIT, 15, maximum wait cycles for one bus access before bus_err (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  start request, level-sampled in IDLE
halt_req  in  1  halt instruction decoded, sampled in T3
pc  in  AW  current program counter from fetch stage
ex_mem_req  in  1  execute stage needs a bus access this instruction, sampled in T1
ex_mem_we  in  1  1 = store, 0 = load, sampled with ex_mem_req
ex_addr  in  AW  load/store address, sampled with ex_mem_req
bus_ready  in  1  memory completes the current access this cycle
t0  out  1  beat 0 strobe (fetch stage captures IR, pc += 2)
t1  out  1  beat 1 strobe
t2  out  1  beat 2 strobe (memory beat, may stretch)
t3  out  1  beat 3 strobe (writeback, jump pc update)
bus_rd  out  1  bus read command
bus_wr  out  1  bus write command
bus_addr  out  AW  bus address
bus_owner  out  1  0 = fetch, 1 = execute
running  out  1  sequencer active (not IDLE, not ERR)
bus_err  out  1  sticky timeout flag
retired  out  CNT_W  count of completed T3 beats

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, wait counter 0, latched request cleared.
- All outputs are registered.
- States: IDLE, IF, T0, T1, T2, T3, ERR.
- IDLE:
  - run=1 -> IF next cycle.
  - Otherwise stay in IDLE.
- IF (instruction fetch):
  - bus_rd=1, bus_owner=0, bus_addr=pc, wait counter increments each cycle.
  - bus_ready=1 -> T0 next cycle, counter cleared.
  - No t strobe is asserted in IF.
- T0: t0=1 for exactly 1 cycle -> T1.
- T1:
  - t1=1 for 1 cycle.
  - Latch ex_mem_req, ex_mem_we and ex_addr.
  - -> T2.
- T2: t2=1.
  - Latched request = 0: T2 lasts exactly 1 cycle -> T3.
  - Latched request = 1: bus_owner=1, bus_addr=ex_addr, bus_wr=ex_mem_we, bus_rd=!ex_mem_we.
  - t2 and the bus command hold until bus_ready=1 -> T3.
- T3:
  - t3=1 for 1 cycle; retired += 1, wrapping modulo 2^CNT_W.
  - halt_req=1 -> IDLE; otherwise -> IF.
- bus_rd/bus_wr are deasserted in the cycle after bus_ready is sampled high; never both high.
- bus_ready while no command is outstanding is ignored.
- Timeout:
  - Wait counter counts cycles with a command outstanding and bus_ready=0.
  - Counter reaching WAIT_LIMIT -> ERR next cycle: bus_err=1, bus commands and strobes dropped, running=0.
  - ERR is left only by reset.
- Exactly one of t0..t3 is high during T0..T3; none is high in IDLE, IF or ERR.
- run while already running is ignored.
- halt_req outside T3 is ignored.
- Reset asserted mid-access aborts immediately: bus_rd/bus_wr drop asynchronously.
- bus_ready=1 in the first IF cycle gives the minimum instruction time: 5 cycles (IF, T0, T1, T2, T3).

Test Plan:
- Reset then run=1 for 1 cycle, pc=0x0000, bus_ready tied 1 -> bus_rd at addr 0x0000 for 1 cycle, then t0,t1,t2,t3 in consecutive cycles, repeating every 5 cycles; retired increments every 5 cycles.
- Fetch with bus_ready delayed 3 cycles -> bus_rd/bus_addr=pc held 4 cycles, t0 rises the cycle after bus_ready, no strobe during wait.
- ex_mem_req=1, ex_mem_we=1, ex_addr=0x0040 at T1, bus_ready after 2 cycles -> t2 high 3 cycles, bus_wr=1, bus_owner=1, bus_addr=0x0040, bus_rd=0 throughout.
- halt_req=1 at T3 -> IDLE next cycle, running=0, no further bus_rd; a later run=1 restarts at IF with the current pc.
- bus_ready held 0 during fetch, WAIT_LIMIT=15 -> after 15 wait cycles bus_err=1 and bus_rd=0; run pulses are ignored; only rst=0 clears bus_err.
- rst=0 pulsed mid-T2 with a load outstanding -> all outputs 0 immediately; retired=0 after reset.
